nasti_stream_slice_mod: RTL and testbench
=========================================

// Module: nasti_stream_slice_mod
// PURPOSE
//  Registered NASTI-stream slice with in-flight field modification, next generation of the
//  stream modifier. Two-entry skid buffer: full throughput, all outputs driven from flops.
//  Per packet it can override ID, force KEEP/STRB and split over-long packets at a beat limit.
//  Sits between any NASTI-stream producer and consumer, e.g. DMA engine to network/video sink.
// PARAMETERS
//  DATA_WIDTH  64  t_data width; STRB/KEEP width = DATA_WIDTH/8
//  ID_WIDTH    8   t_id width
//  USER_WIDTH  8   t_user width
//  CNT_WIDTH   16  beat-counter and cfg_max_beats width
// PORTS
//  clk            in   1      clock
//  rst            in   1      synchronous reset, active-high
//  m_t_valid/ready/data/strb/keep/last/id/user  in/out/in...  upstream beat (ready is out)
//  s_t_valid/ready/data/strb/keep/last/id/user  out/in/out... downstream beat (ready is in)
//  cfg_id_en      in   1            replace t_id with cfg_id
//  cfg_id         in   ID_WIDTH     replacement id
//  cfg_keep_all   in   1            force KEEP and STRB to all-ones
//  cfg_max_beats  in   CNT_WIDTH    split limit in beats; 0 = no splitting
//  split_pulse    out  1            1-cycle pulse when a forced t_last is inserted
// BEHAVIOUR
//  - One clock, clk; reset rst is synchronous and active-high. Reset wins over every other event.
//  - Buffer occupancy cnt in {0,1,2}; m_t_ready = (cnt!=2), registered; s_t_valid = (cnt!=0).
//  - Push = m_t_valid&m_t_ready; pop = s_t_valid&s_t_ready. Order FIFO, head drives s_t_*.
//  - cnt transitions: push&!pop +1; pop&!push -1; push&pop hold (only legal at cnt=1,
//    or at cnt=2 with pop only). At cnt=2 no push possible; pop frees a slot next cycle.
//  - Latency: beat pushed at cycle N is visible on s_t_* at cycle N+1. Throughput 1 beat/clk
//    with s_t_ready held high; back-pressure absorbed without bubble by skid entry.
//  - Payload held stable while s_t_valid&!s_t_ready (AXI-stream rules on output side).
//  - Config latched into shadow regs on the first beat of each packet (in_pkt==0 at push);
//    changes mid-packet take effect on the next packet only.
//  - Modifications applied at push: id = cfg_id_en ? cfg_id : m_t_id;
//    keep,strb = cfg_keep_all ? '1 : m_t_keep, m_t_strb & m_t_keep.
//  - Beat counter bcnt (CNT_WIDTH) counts pushes in current packet starting at 1.
//    If max!=0 and bcnt==max and !m_t_last: stored last=1, split_pulse=1 next cycle,
//    bcnt restarts, following beat is first of new packet (config re-latched).
//    Real m_t_last: bcnt cleared, in_pkt=0. Last beat coinciding with limit: no pulse.
//  - bcnt never wraps: saturates at all-ones when max==0.
//  - Reset values: cnt=0, s_t_valid=0, m_t_ready=0 during rst then 1 the cycle after,
//    split_pulse=0, bcnt=0, in_pkt=0, shadow cfg=0, s_t_* payload=0.
//  - Reset mid-packet: buffered beats discarded, no t_last emitted; next push starts a packet.
// CONFIGURATION
//  NASTI_STREAM_SLICE_STATS_EN defined: adds outputs stat_beats, stat_pkts, stat_splits
//  (32 b each, counted at pop; pkts counts output t_last incl. forced; splits counts forced;
//  wrap modulo 2^32; cleared by rst). Undefined: ports and counters absent, all else identical.
// TESTING
//  1 rst 3 clks, then 8-beat packet, s_t_ready=1 -> 8 beats out, 1 clk latency, last on beat 8.
//  2 s_t_ready=0 for 5 clks mid-packet -> cnt 2, m_t_ready=0, no beat lost/duplicated, order kept.
//  3 cfg_max_beats=3, 7-beat packet -> last on out beats 3,6,7; split_pulse twice.
//  4 cfg_id_en=1 cfg_id=0x5A, toggled to 0x11 at beat 2 -> whole packet id 0x5A, next 0x11.
//  5 cfg_keep_all=1, keep=0x0F strb=0x03 -> out keep=0xFF strb=0xFF; cleared -> strb 0x03.
//  6 rst asserted with cnt=2 -> next clk s_t_valid=0, split_pulse=0; STATS_EN counters zero.

Source files
------------

// File: rtl/nasti_stream_slice_mod_if.sv
// rtl/nasti_stream_slice_mod_if.sv - NASTI-stream beat interface with producer/consumer modports
interface nasti_stream_slice_mod_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 8
);
  logic                    t_valid;
  logic                    t_ready;
  logic [DATA_WIDTH-1:0]   t_data;
  logic [DATA_WIDTH/8-1:0] t_strb;
  logic [DATA_WIDTH/8-1:0] t_keep;
  logic                    t_last;
  logic [ID_WIDTH-1:0]     t_id;
  logic [USER_WIDTH-1:0]   t_user;

  modport master (output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_user,
                  input  t_ready);
  modport slave  (input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_user,
                  output t_ready);
endinterface

// File: rtl/nasti_stream_slice_mod.sv
// rtl/nasti_stream_slice_mod.sv - two-entry registered stream slice with id/keep override and packet splitting
// Optional statistics counters: define NASTI_STREAM_SLICE_STATS_EN.
module nasti_stream_slice_mod #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  nasti_stream_slice_mod_if.slave  m,
  nasti_stream_slice_mod_if.master s,
  input  logic                    cfg_id_en,
  input  logic [ID_WIDTH-1:0]     cfg_id,
  input  logic                    cfg_keep_all,
  input  logic [CNT_WIDTH-1:0]    cfg_max_beats,
  output logic                    split_pulse
`ifdef NASTI_STREAM_SLICE_STATS_EN
  ,
  output logic [31:0]             stat_beats,
  output logic [31:0]             stat_pkts,
  output logic [31:0]             stat_splits
`endif
);
  localparam int KW = DATA_WIDTH / 8;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0]         strb;
    logic [KW-1:0]         keep;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_FULL} occ_e;

  occ_e  occ_q, occ_d;
  beat_t head_q, skid_q, in_beat;
  logic  m_ready_q, s_valid_q;
  logic  push, pop;
  logic  head_from_in, head_from_skid, skid_from_in;

  logic                 in_pkt_q;
  logic [CNT_WIDTH-1:0] bcnt_q, beat_num;
  logic                 sh_id_en_q, sh_keep_all_q;
  logic [ID_WIDTH-1:0]  sh_id_q;
  logic [CNT_WIDTH-1:0] sh_max_q;
  logic                 eff_id_en, eff_keep_all;
  logic [ID_WIDTH-1:0]  eff_id;
  logic [CNT_WIDTH-1:0] eff_max;
  logic                 split_here;

  assign push = m.t_valid & m_ready_q;
  assign pop  = s_valid_q & s.t_ready;

  // Head register feeds the outputs directly; skid only fills when the head is stalled.
  always_comb begin
    occ_d          = occ_q;
    head_from_in   = 1'b0;
    head_from_skid = 1'b0;
    skid_from_in   = 1'b0;
    case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          occ_d        = OCC_ONE;
          head_from_in = 1'b1;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          head_from_in = 1'b1;
        end else if (push) begin
          occ_d        = OCC_FULL;
          skid_from_in = 1'b1;
        end else if (pop) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          occ_d          = OCC_ONE;
          head_from_skid = 1'b1;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // First beat of a packet uses live config; later beats use the copy latched with it.
  assign eff_id_en    = in_pkt_q ? sh_id_en_q    : cfg_id_en;
  assign eff_id       = in_pkt_q ? sh_id_q       : cfg_id;
  assign eff_keep_all = in_pkt_q ? sh_keep_all_q : cfg_keep_all;
  assign eff_max      = in_pkt_q ? sh_max_q      : cfg_max_beats;

  assign beat_num   = !in_pkt_q ? CNT_WIDTH'(1) :
                      (&bcnt_q) ? bcnt_q : bcnt_q + CNT_WIDTH'(1);
  assign split_here = (eff_max != '0) && (beat_num == eff_max) && !m.t_last;

  always_comb begin
    in_beat      = '0;
    in_beat.data = m.t_data;
    in_beat.strb = eff_keep_all ? {KW{1'b1}} : (m.t_strb & m.t_keep);
    in_beat.keep = eff_keep_all ? {KW{1'b1}} : m.t_keep;
    in_beat.last = m.t_last | split_here;
    in_beat.id   = eff_id_en ? eff_id : m.t_id;
    in_beat.user = m.t_user;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q         <= OCC_EMPTY;
      m_ready_q     <= 1'b0;
      s_valid_q     <= 1'b0;
      head_q        <= '0;
      skid_q        <= '0;
      split_pulse   <= 1'b0;
      bcnt_q        <= '0;
      in_pkt_q      <= 1'b0;
      sh_id_en_q    <= 1'b0;
      sh_id_q       <= '0;
      sh_keep_all_q <= 1'b0;
      sh_max_q      <= '0;
    end else begin
      occ_q     <= occ_d;
      m_ready_q <= (occ_d != OCC_FULL);
      s_valid_q <= (occ_d != OCC_EMPTY);
      if (head_from_in)
        head_q <= in_beat;
      else if (head_from_skid)
        head_q <= skid_q;
      if (skid_from_in)
        skid_q <= in_beat;
      split_pulse <= push & split_here;
      if (push) begin
        if (!in_pkt_q) begin
          sh_id_en_q    <= cfg_id_en;
          sh_id_q       <= cfg_id;
          sh_keep_all_q <= cfg_keep_all;
          sh_max_q      <= cfg_max_beats;
        end
        if (m.t_last || split_here) begin
          bcnt_q   <= '0;
          in_pkt_q <= 1'b0;
        end else begin
          bcnt_q   <= beat_num;
          in_pkt_q <= 1'b1;
        end
      end
    end
  end

  assign m.t_ready = m_ready_q;
  assign s.t_valid = s_valid_q;
  assign s.t_data  = head_q.data;
  assign s.t_strb  = head_q.strb;
  assign s.t_keep  = head_q.keep;
  assign s.t_last  = head_q.last;
  assign s.t_id    = head_q.id;
  assign s.t_user  = head_q.user;

`ifdef NASTI_STREAM_SLICE_STATS_EN
  // Forced-last marker travels alongside each buffered beat so splits are counted at pop.
  logic head_split_q, skid_split_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_split_q <= 1'b0;
      skid_split_q <= 1'b0;
      stat_beats   <= '0;
      stat_pkts    <= '0;
      stat_splits  <= '0;
    end else begin
      if (head_from_in)
        head_split_q <= split_here;
      else if (head_from_skid)
        head_split_q <= skid_split_q;
      if (skid_from_in)
        skid_split_q <= split_here;
      if (pop) begin
        stat_beats <= stat_beats + 32'd1;
        if (head_q.last)
          stat_pkts <= stat_pkts + 32'd1;
        if (head_split_q)
          stat_splits <= stat_splits + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_nasti_stream_slice_mod.sv
// tb/tb_nasti_stream_slice_mod.sv - scoreboard bench for nasti_stream_slice_mod
`timescale 1ns/1ps
module tb_nasti_stream_slice_mod;
  localparam int DW = 64;
  localparam int IW = 8;
  localparam int UW = 8;
  localparam int CW = 16;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nasti_stream_slice_mod_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) m_if ();
  nasti_stream_slice_mod_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) s_if ();

  logic          cfg_id_en     = 1'b0;
  logic [IW-1:0] cfg_id        = '0;
  logic          cfg_keep_all  = 1'b0;
  logic [CW-1:0] cfg_max_beats = '0;
  logic          split_pulse;
`ifdef NASTI_STREAM_SLICE_STATS_EN
  logic [31:0]   stat_beats, stat_pkts, stat_splits;
`endif

  nasti_stream_slice_mod #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .m             (m_if),
    .s             (s_if),
    .cfg_id_en     (cfg_id_en),
    .cfg_id        (cfg_id),
    .cfg_keep_all  (cfg_keep_all),
    .cfg_max_beats (cfg_max_beats),
    .split_pulse   (split_pulse)
`ifdef NASTI_STREAM_SLICE_STATS_EN
    ,
    .stat_beats    (stat_beats),
    .stat_pkts     (stat_pkts),
    .stat_splits   (stat_splits)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] strb;
    logic [KW-1:0] keep;
    logic          last;
    logic [IW-1:0] id;
    logic [UW-1:0] user;
  } beat_t;

  beat_t exp_q[$];
  int    push_cyc_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  bit    rst_at_edge = 1'b1;
  int    stall_mode = 0;
  bit    check_lat = 1'b0;
  int    pulses_seen = 0;
  int    pulses_exp = 0;

  // Reference model: packet state as the spec describes it (config snapshot per packet, beat position).
  bit            mdl_in_pkt = 1'b0;
  int            mdl_pos = 0;
  bit            mdl_id_en, mdl_keep_all;
  logic [IW-1:0] mdl_id;
  int            mdl_max;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = rst;
  end

  // Monitor: drives downstream ready, pops the scoreboard on every accepted output beat.
  beat_t prev_beat;
  bit    prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t act, exp;
    int    pc;
    case (stall_mode)
      0:       s_if.t_ready = 1'b1;
      1:       s_if.t_ready = ($urandom_range(0, 3) != 0);
      default: s_if.t_ready = 1'b0;
    endcase
    act.data = s_if.t_data;
    act.strb = s_if.t_strb;
    act.keep = s_if.t_keep;
    act.last = s_if.t_last;
    act.id   = s_if.t_id;
    act.user = s_if.t_user;
    if (rst_at_edge) begin
      prev_stall = 1'b0;
    end else begin
      if (split_pulse) pulses_seen++;
      if (prev_stall) begin
        check("valid_held", s_if.t_valid, 1);
        check("payload_held", act, prev_beat);
      end
      if (s_if.t_valid && s_if.t_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", act);
        end else begin
          exp = exp_q.pop_front();
          pc  = push_cyc_q.pop_front();
          check("beat", act, exp);
          if (check_lat) check("latency", cyc - pc, 1);
        end
      end
      prev_stall = s_if.t_valid && !s_if.t_ready;
    end
    prev_beat = act;
  end

  task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic [KW-1:0] st,
                            input logic l, input logic [IW-1:0] id, input logic [UW-1:0] u);
    int    t = 0;
    bit    forced;
    beat_t e;
    m_if.t_valid = 1'b1;
    m_if.t_data  = d;
    m_if.t_keep  = k;
    m_if.t_strb  = st;
    m_if.t_last  = l;
    m_if.t_id    = id;
    m_if.t_user  = u;
    while (!m_if.t_ready) begin
      @(negedge clk);
      t++;
      if (t > 300) begin
        checks++;
        errors++;
        $display("FAIL push_timeout: got ready=0 for %0d cycles expected ready", t);
        return;
      end
    end
    if (!mdl_in_pkt) begin
      mdl_id_en    = cfg_id_en;
      mdl_id       = cfg_id;
      mdl_keep_all = cfg_keep_all;
      mdl_max      = int'(cfg_max_beats);
      mdl_pos      = 0;
    end
    mdl_pos++;
    forced = (mdl_max != 0) && (mdl_pos == mdl_max) && !l;
    e.data = d;
    e.user = u;
    e.id   = mdl_id_en ? mdl_id : id;
    e.keep = mdl_keep_all ? {KW{1'b1}} : k;
    e.strb = mdl_keep_all ? {KW{1'b1}} : (st & k);
    e.last = l | forced;
    if (forced) pulses_exp++;
    mdl_in_pkt = !e.last;
    exp_q.push_back(e);
    push_cyc_q.push_back(cyc);
    @(negedge clk);
  endtask

  task automatic randomize_cfg();
    int sel;
    sel           = $urandom_range(0, 4);
    cfg_id_en     = $urandom_range(0, 1);
    cfg_id        = IW'($urandom);
    cfg_keep_all  = ($urandom_range(0, 3) == 0);
    cfg_max_beats = (sel == 0) ? CW'(0) : (sel == 4) ? CW'(5) : CW'(sel);
  endtask

  task automatic send_pkt(input int len, input bit fixed_ks, input bit rnd,
                          input int chg_at, input logic [IW-1:0] chg_id);
    logic [KW-1:0] k, st;
    for (int i = 0; i < len; i++) begin
      if (i == chg_at) cfg_id = chg_id;
      if (rnd) begin
        if ($urandom_range(0, 3) == 0) randomize_cfg();
        if ($urandom_range(0, 2) == 0) begin
          m_if.t_valid = 1'b0;
          repeat ($urandom_range(1, 2)) @(negedge clk);
        end
      end
      k  = fixed_ks ? KW'(8'h0F) : KW'($urandom);
      st = fixed_ks ? KW'(8'h03) : KW'($urandom);
      drive_beat({$urandom, $urandom}, k, st, (i == len - 1), IW'($urandom), UW'($urandom));
    end
    m_if.t_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int p0;
    m_if.t_valid = 1'b0;
    m_if.t_data  = '0;
    m_if.t_strb  = '0;
    m_if.t_keep  = '0;
    m_if.t_last  = 1'b0;
    m_if.t_id    = '0;
    m_if.t_user  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_valid", s_if.t_valid, 0);
    check("rst_m_ready", m_if.t_ready, 0);
    check("rst_split_pulse", split_pulse, 0);
    check("rst_s_data", s_if.t_data, 0);
    check("rst_s_last", s_if.t_last, 0);
`ifdef NASTI_STREAM_SLICE_STATS_EN
    check("rst_stat_beats", stat_beats, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("m_ready_after_rst", m_if.t_ready, 1);

    // 8-beat packet, continuous flow, single-cycle latency
    check_lat = 1'b1;
    send_pkt(8, 1'b0, 1'b0, -1, '0);
    drain();
    check_lat = 1'b0;

    // downstream stall mid-packet fills both entries
    fork
      send_pkt(10, 1'b0, 1'b0, -1, '0);
      begin
        repeat (3) @(negedge clk);
        stall_mode = 2;
        repeat (5) @(negedge clk);
        check("stall_m_ready_low", m_if.t_ready, 0);
        check("stall_s_valid_high", s_if.t_valid, 1);
        stall_mode = 0;
      end
    join
    drain();

    // split every 3 beats: lasts on beats 3, 6, 7
    cfg_max_beats = CW'(3);
    p0 = pulses_seen;
    send_pkt(7, 1'b0, 1'b0, -1, '0);
    drain();
    check("split_pulses_7_by_3", pulses_seen - p0, 2);
    cfg_max_beats = '0;

    // id override latched per packet
    cfg_id_en = 1'b1;
    cfg_id    = IW'(8'h5A);
    send_pkt(4, 1'b0, 1'b0, 2, IW'(8'h11));
    send_pkt(3, 1'b0, 1'b0, -1, '0);
    drain();
    cfg_id_en = 1'b0;

    // keep/strb force, then normal masking
    cfg_keep_all = 1'b1;
    send_pkt(3, 1'b1, 1'b0, -1, '0);
    cfg_keep_all = 1'b0;
    send_pkt(3, 1'b1, 1'b0, -1, '0);
    drain();

    // reset with both entries occupied mid-packet
    cfg_max_beats = CW'(3);
    stall_mode = 2;
    @(negedge clk);
    drive_beat({$urandom, $urandom}, '1, '1, 1'b0, 8'h01, 8'h02);
    drive_beat({$urandom, $urandom}, '1, '1, 1'b0, 8'h03, 8'h04);
    check("full_m_ready_low", m_if.t_ready, 0);
    m_if.t_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_s_valid", s_if.t_valid, 0);
    check("midrst_split_pulse", split_pulse, 0);
    check("midrst_m_ready", m_if.t_ready, 0);
`ifdef NASTI_STREAM_SLICE_STATS_EN
    check("midrst_stat_beats", stat_beats, 0);
    check("midrst_stat_pkts", stat_pkts, 0);
    check("midrst_stat_splits", stat_splits, 0);
`endif
    exp_q.delete();
    push_cyc_q.delete();
    mdl_in_pkt = 1'b0;
    rst = 1'b0;
    stall_mode = 0;
    @(negedge clk);
    send_pkt(4, 1'b0, 1'b0, -1, '0);
    drain();
    cfg_max_beats = '0;

    // randomized traffic, config churn and back-pressure
    stall_mode = 1;
    for (int n = 0; n < 40; n++) begin
      randomize_cfg();
      send_pkt($urandom_range(1, 12), 1'b0, 1'b1, -1, '0);
    end
    stall_mode = 0;
    drain();
    check("split_pulse_total", pulses_seen, pulses_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
